// File: rtl/ntm_write_heads_engine_if.sv
// Control, vector-load, memory-stream and result signals of the NTM write-head engine.
// The engine connects through the slave modport; the controller and memory side use master.
interface ntm_write_heads_engine_if #(parameter int DATA_SIZE = 16);
  logic                        START;
  logic                        READY;
  logic                        MODE;
  logic        [DATA_SIZE-1:0] SIZE_N_IN;
  logic        [DATA_SIZE-1:0] SIZE_W_IN;
  logic                        E_IN_ENABLE;
  logic signed [DATA_SIZE-1:0] E_IN;
  logic                        A_IN_ENABLE;
  logic signed [DATA_SIZE-1:0] A_IN;
  logic                        W_IN_ENABLE;
  logic signed [DATA_SIZE-1:0] W_IN;
  logic                        M_IN_ENABLE;
  logic signed [DATA_SIZE-1:0] M_IN;
  logic                        M_OUT_ENABLE;
  logic signed [DATA_SIZE-1:0] M_OUT;
  logic                        M_OUT_K_ENABLE;
  logic                        M_OUT_J_ENABLE;
  logic                        ERROR;

  modport master (
    output START, MODE, SIZE_N_IN, SIZE_W_IN, E_IN_ENABLE, E_IN, A_IN_ENABLE, A_IN,
           W_IN_ENABLE, W_IN, M_IN_ENABLE, M_IN,
    input  READY, M_OUT_ENABLE, M_OUT, M_OUT_K_ENABLE, M_OUT_J_ENABLE, ERROR
  );

  modport slave (
    input  START, MODE, SIZE_N_IN, SIZE_W_IN, E_IN_ENABLE, E_IN, A_IN_ENABLE, A_IN,
           W_IN_ENABLE, W_IN, M_IN_ENABLE, M_IN,
    output READY, M_OUT_ENABLE, M_OUT, M_OUT_K_ENABLE, M_OUT_J_ENABLE, ERROR
  );
endinterface

// File: rtl/ntm_write_heads_engine.sv
// NTM write head: M' = M*(1 - w*e) + w*a, streamed row by row; output 2 cycles after the accepting edge.
// No backpressure: every accepted M_IN element yields exactly one M_OUT element, in order.
module ntm_write_heads_engine #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_SIZE = 8,
  parameter int MAX_W     = 16,
  parameter int MAX_N     = 64
) (
  input logic CLK,
  input logic RST,
  ntm_write_heads_engine_if.slave bus
);
  localparam int DW = DATA_SIZE;
  localparam int KW = $clog2(MAX_W);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_E = 3'd1;
  localparam logic [2:0] LOAD_A = 3'd2;
  localparam logic [2:0] WAIT_W = 3'd3;
  localparam logic [2:0] ROW    = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;

  function automatic logic signed [DW-1:0] sat_prod(input logic signed [2*DW-1:0] p);
    logic signed [2*DW-1:0] s;
    s = p >>> FRAC_SIZE;
    if (s[2*DW-1:DW-1] == {(DW+1){s[2*DW-1]}}) return s[DW-1:0];
    return s[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] sat_sum(input logic signed [DW+1:0] s);
    if (s[DW+1:DW-1] == {3{s[DW+1]}}) return s[DW-1:0];
    return s[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic [2:0]           state_q, state_d;
  logic                 mode_q, mode_d;
  logic [DW-1:0]        n_q, n_d, w_q, w_d, j_q, j_d, k_q, k_d;
  logic signed [DW-1:0] wreg_q, wreg_d;
  logic                 err_q, err_d;
  logic                 e_we, a_we, take_m, last_k, last_j, bad_size;

  logic signed [DW-1:0] e_buf [MAX_W];
  logic signed [DW-1:0] a_buf [MAX_W];

  // c0: element captured at the accepting edge; s1: products; out: result registers
  logic                 c0_vld_q, c0_k_q, c0_j_q;
  logic signed [DW-1:0] c0_m_q, c0_w_q, c0_e_q, c0_a_q;
  logic                 s1_vld_q, s1_k_q, s1_j_q;
  logic signed [DW-1:0] s1_m_q, s1_we_q, s1_wa_q;
  logic                 out_vld_q, out_k_q, out_j_q;
  logic signed [DW-1:0] out_m_q;

  logic signed [2*DW-1:0] p_we, p_wa, p_mw;
  logic signed [DW-1:0]   we_c, wa_c, mw_c;
  logic signed [DW+1:0]   sum_c;

  assign last_k   = (k_q == w_q - DW'(1));
  assign last_j   = (j_q == n_q - DW'(1));
  assign bad_size = (bus.SIZE_N_IN == '0) || (bus.SIZE_W_IN == '0) ||
                    (bus.SIZE_N_IN > DW'(MAX_N)) || (bus.SIZE_W_IN > DW'(MAX_W));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    w_d     = w_q;
    j_d     = j_q;
    k_d     = k_q;
    wreg_d  = wreg_q;
    err_d   = err_q;
    e_we    = 1'b0;
    a_we    = 1'b0;
    take_m  = 1'b0;
    case (state_q)
      IDLE: if (bus.START) begin
        mode_d = bus.MODE;
        n_d    = bus.SIZE_N_IN;
        w_d    = bus.SIZE_W_IN;
        j_d    = '0;
        k_d    = '0;
        err_d  = bad_size;
        if (!bad_size) state_d = bus.MODE ? LOAD_E : LOAD_A;
      end
      LOAD_E: if (bus.E_IN_ENABLE) begin
        e_we = 1'b1;
        k_d  = last_k ? '0 : k_q + DW'(1);
        if (last_k) state_d = LOAD_A;
      end
      LOAD_A: if (bus.A_IN_ENABLE) begin
        a_we = 1'b1;
        k_d  = last_k ? '0 : k_q + DW'(1);
        if (last_k) begin
          j_d     = '0;
          state_d = WAIT_W;
        end
      end
      WAIT_W: if (bus.W_IN_ENABLE) begin
        wreg_d  = bus.W_IN;
        k_d     = '0;
        state_d = ROW;
      end
      ROW: if (bus.M_IN_ENABLE) begin
        take_m = 1'b1;
        k_d    = last_k ? '0 : k_q + DW'(1);
        if (last_k) begin
          if (last_j) begin
            state_d = DRAIN;
          end else begin
            j_d     = j_q + DW'(1);
            state_d = WAIT_W;
          end
        end
      end
      DRAIN: if (!c0_vld_q && !s1_vld_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (e_we) e_buf[k_q[KW-1:0]] <= bus.E_IN;
    if (a_we) a_buf[k_q[KW-1:0]] <= bus.A_IN;
  end

  always_comb begin
    p_we  = (2*DW)'(c0_w_q) * (2*DW)'(c0_e_q);
    p_wa  = (2*DW)'(c0_w_q) * (2*DW)'(c0_a_q);
    we_c  = sat_prod(p_we);
    wa_c  = sat_prod(p_wa);
    p_mw  = (2*DW)'(s1_m_q) * (2*DW)'(s1_we_q);
    mw_c  = sat_prod(p_mw);
    // widened sum: M - M*we + wa can exceed the word range by up to two bits
    sum_c = (DW+2)'(s1_m_q) - (DW+2)'(mw_c) + (DW+2)'(s1_wa_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      n_q       <= '0;
      w_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      wreg_q    <= '0;
      err_q     <= 1'b0;
      c0_vld_q  <= 1'b0;
      c0_k_q    <= 1'b0;
      c0_j_q    <= 1'b0;
      c0_m_q    <= '0;
      c0_w_q    <= '0;
      c0_e_q    <= '0;
      c0_a_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_k_q    <= 1'b0;
      s1_j_q    <= 1'b0;
      s1_m_q    <= '0;
      s1_we_q   <= '0;
      s1_wa_q   <= '0;
      out_vld_q <= 1'b0;
      out_k_q   <= 1'b0;
      out_j_q   <= 1'b0;
      out_m_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      n_q       <= n_d;
      w_q       <= w_d;
      j_q       <= j_d;
      k_q       <= k_d;
      wreg_q    <= wreg_d;
      err_q     <= err_d;
      c0_vld_q  <= take_m;
      if (take_m) begin
        c0_m_q <= bus.M_IN;
        c0_w_q <= wreg_q;
        c0_e_q <= mode_q ? e_buf[k_q[KW-1:0]] : '0;
        c0_a_q <= a_buf[k_q[KW-1:0]];
        c0_k_q <= last_k;
        c0_j_q <= last_k && last_j;
      end
      s1_vld_q  <= c0_vld_q;
      s1_m_q    <= c0_m_q;
      s1_we_q   <= we_c;
      s1_wa_q   <= wa_c;
      s1_k_q    <= c0_k_q;
      s1_j_q    <= c0_j_q;
      out_vld_q <= s1_vld_q;
      out_k_q   <= s1_vld_q && s1_k_q;
      out_j_q   <= s1_vld_q && s1_j_q;
      out_m_q   <= s1_vld_q ? sat_sum(sum_c) : '0;
    end
  end

  assign bus.READY          = (state_q == IDLE);
  assign bus.ERROR          = err_q;
  assign bus.M_OUT_ENABLE   = out_vld_q;
  assign bus.M_OUT          = out_m_q;
  assign bus.M_OUT_K_ENABLE = out_k_q;
  assign bus.M_OUT_J_ENABLE = out_j_q;
endmodule

// File: tb/tb_ntm_write_heads_engine.sv
// Randomized and directed bench for ntm_write_heads_engine against an integer-arithmetic reference.
module tb_ntm_write_heads_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntm_write_heads_engine_if #(.DATA_SIZE(16)) bus();

  ntm_write_heads_engine #(.DATA_SIZE(16), .FRAC_SIZE(8), .MAX_W(16), .MAX_N(64)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  typedef struct {
    int val;
    bit k;
    bit j;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0, n_k = 0, n_j = 0;
  int   e_arr [16];
  int   a_arr [16];
  int   w_arr [64];
  int   m_arr [64][16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // M' = M*(1 - w*e) + w*a in Q8.8, each product floored and clamped
  function automatic int ref_elem(input int m, input int w, input int e, input int a);
    longint we, wa, mw;
    we = sat16((longint'(w) * longint'(e)) >>> 8);
    wa = sat16((longint'(w) * longint'(a)) >>> 8);
    mw = sat16((longint'(m) * we) >>> 8);
    return sat16(longint'(m) - mw + wa);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.M_OUT_ENABLE) begin
      exp_t x;
      n_out++;
      if (bus.M_OUT_K_ENABLE) n_k++;
      if (bus.M_OUT_J_ENABLE) n_j++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got val=%0d at cyc %0d required no output", bus.M_OUT, cyc);
      end else begin
        x = exp_q.pop_front();
        if (int'(bus.M_OUT) != x.val || bus.M_OUT_K_ENABLE != x.k ||
            bus.M_OUT_J_ENABLE != x.j || cyc != x.cyc) begin
          errors++;
          $display("FAIL out got val=%0d k=%0b j=%0b cyc=%0d required val=%0d k=%0b j=%0b cyc=%0d",
                   bus.M_OUT, bus.M_OUT_K_ENABLE, bus.M_OUT_J_ENABLE, cyc, x.val, x.k, x.j, x.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // idle cycles; kind 0 drives strobes ignored during loads, 1 a W strobe inside a row, 2 an M strobe while waiting for w
  task automatic gap(input bit en, input int kind);
    if (en && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        bus.W_IN = 16'($urandom);
        bus.M_IN = 16'($urandom);
        bus.W_IN_ENABLE = (kind != 2);
        bus.M_IN_ENABLE = (kind != 1);
        tick();
        bus.W_IN_ENABLE = 1'b0;
        bus.M_IN_ENABLE = 1'b0;
      end
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40 && !bus.READY; i++) tick();
    chk(name, int'(bus.READY), 1);
  endtask

  task automatic run_op(input bit mode, input int n, input int w, input bit gaps);
    bus.START = 1'b1;
    bus.MODE = mode;
    bus.SIZE_N_IN = 16'(n);
    bus.SIZE_W_IN = 16'(w);
    tick();
    bus.START = 1'b0;
    chk("ready_drop", int'(bus.READY), 0);
    chk("error_clear", int'(bus.ERROR), 0);
    if (mode) begin
      for (int k = 0; k < w; k++) begin
        gap(gaps, 0);
        bus.E_IN = 16'(e_arr[k]);
        bus.E_IN_ENABLE = 1'b1;
        tick();
        bus.E_IN_ENABLE = 1'b0;
      end
    end
    for (int k = 0; k < w; k++) begin
      gap(gaps, 0);
      bus.A_IN = 16'(a_arr[k]);
      bus.A_IN_ENABLE = 1'b1;
      tick();
      bus.A_IN_ENABLE = 1'b0;
    end
    for (int j = 0; j < n; j++) begin
      gap(gaps, 2);
      bus.W_IN = 16'(w_arr[j]);
      bus.W_IN_ENABLE = 1'b1;
      tick();
      bus.W_IN_ENABLE = 1'b0;
      for (int k = 0; k < w; k++) begin
        exp_t x;
        if (k > 0) gap(gaps, 1);
        x.val = ref_elem(m_arr[j][k], w_arr[j], mode ? e_arr[k] : 0, a_arr[k]);
        x.k = (k == w - 1);
        x.j = (k == w - 1) && (j == n - 1);
        x.cyc = cyc + 3;
        exp_q.push_back(x);
        bus.M_IN = 16'(m_arr[j][k]);
        bus.M_IN_ENABLE = 1'b1;
        tick();
        bus.M_IN_ENABLE = 1'b0;
      end
    end
    wait_ready("ready_return");
    chk("all_outputs_seen", exp_q.size(), 0);
  endtask

  task automatic load_basic();
    e_arr[0] = 256; e_arr[1] = 0;
    a_arr[0] = 128; a_arr[1] = 512;
    w_arr[0] = 256; w_arr[1] = 128;
    for (int j = 0; j < 2; j++) for (int k = 0; k < 2; k++) m_arr[j][k] = 1000;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, k0, j0;
    bus.START = 0; bus.MODE = 0; bus.SIZE_N_IN = 0; bus.SIZE_W_IN = 0;
    bus.E_IN_ENABLE = 0; bus.E_IN = 0; bus.A_IN_ENABLE = 0; bus.A_IN = 0;
    bus.W_IN_ENABLE = 0; bus.W_IN = 0; bus.M_IN_ENABLE = 0; bus.M_IN = 0;
    repeat (3) tick();
    chk("rst_ready", int'(bus.READY), 1);
    chk("rst_out_en", int'(bus.M_OUT_ENABLE), 0);
    chk("rst_out", int'(bus.M_OUT), 0);
    chk("rst_flags", int'({bus.M_OUT_K_ENABLE, bus.M_OUT_J_ENABLE}), 0);
    chk("rst_error", int'(bus.ERROR), 0);
    rst_n = 1'b1;
    tick();

    // hand-derived Q8.8 values that anchor the reference model
    chk("model_r0k0", ref_elem(1000, 256, 256, 128), 128);
    chk("model_r0k1", ref_elem(1000, 256, 0, 512), 1512);
    chk("model_r1k0", ref_elem(1000, 128, 256, 128), 564);
    chk("model_r1k1", ref_elem(1000, 128, 0, 512), 1256);
    chk("model_add_only", ref_elem(1000, 256, 0, 128), 1128);
    chk("model_add_only_w1", ref_elem(1000, 128, 0, 128), 1064);
    chk("model_sat_hi", ref_elem(32767, 256, 0, 32767), 32767);
    chk("model_sat_lo", ref_elem(-32768, 256, 0, -32768), -32768);

    load_basic();
    run_op(1'b1, 2, 2, 1'b0);
    run_op(1'b0, 2, 2, 1'b0);

    w_arr[0] = 256; a_arr[0] = 32767; m_arr[0][0] = 32767;
    run_op(1'b0, 1, 1, 1'b0);
    a_arr[0] = -32768; m_arr[0][0] = -32768;
    run_op(1'b0, 1, 1, 1'b0);

    bus.START = 1'b1; bus.MODE = 1'b1; bus.SIZE_N_IN = 16'd2; bus.SIZE_W_IN = 16'd17;
    tick();
    bus.START = 1'b0;
    chk("err_w_big", int'(bus.ERROR), 1);
    chk("err_ready", int'(bus.READY), 1);
    repeat (4) tick();
    chk("err_sticky", int'(bus.ERROR), 1);
    bus.START = 1'b1; bus.SIZE_N_IN = 16'd0; bus.SIZE_W_IN = 16'd2;
    tick();
    bus.START = 1'b0;
    chk("err_n_zero", int'(bus.ERROR), 1);
    bus.START = 1'b1; bus.SIZE_N_IN = 16'd65; bus.SIZE_W_IN = 16'd16;
    tick();
    bus.START = 1'b0;
    chk("err_n_big", int'(bus.ERROR), 1);
    load_basic();
    run_op(1'b1, 2, 2, 1'b0);

    // abort with one element in flight: it must never appear
    bus.START = 1'b1; bus.MODE = 1'b1; bus.SIZE_N_IN = 16'd2; bus.SIZE_W_IN = 16'd2;
    tick();
    bus.START = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.E_IN = 16'(e_arr[k]); bus.E_IN_ENABLE = 1'b1; tick(); bus.E_IN_ENABLE = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      bus.A_IN = 16'(a_arr[k]); bus.A_IN_ENABLE = 1'b1; tick(); bus.A_IN_ENABLE = 1'b0;
    end
    bus.W_IN = 16'(w_arr[0]); bus.W_IN_ENABLE = 1'b1; tick(); bus.W_IN_ENABLE = 1'b0;
    bus.M_IN = 16'd1000; bus.M_IN_ENABLE = 1'b1; tick(); bus.M_IN_ENABLE = 1'b0;
    rst_n = 1'b0;
    o0 = n_out;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("abort_no_output", n_out - o0, 0);
    chk("abort_ready", int'(bus.READY), 1);
    chk("abort_error", int'(bus.ERROR), 0);
    run_op(1'b1, 2, 2, 1'b0);

    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 16; k++) begin
        e_arr[k] = (pass == 0) ? $urandom_range(0, 256) : rnd16();
        a_arr[k] = rnd16();
      end
      for (int j = 0; j < 4; j++) begin
        w_arr[j] = (pass == 0) ? $urandom_range(0, 256) : rnd16();
        for (int k = 0; k < 16; k++) m_arr[j][k] = rnd16();
      end
      o0 = n_out; k0 = n_k; j0 = n_j;
      run_op(1'b1, 4, 16, 1'b1);
      chk("rand_count", n_out - o0, 64);
      chk("rand_k_flags", n_k - k0, 4);
      chk("rand_j_flags", n_j - j0, 1);
    end

    o0 = n_out; k0 = n_k; j0 = n_j;
    run_op(1'b0, 4, 16, 1'b1);
    chk("rand_add_count", n_out - o0, 64);
    chk("rand_add_flags", (n_k - k0) * 10 + (n_j - j0), 41);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
